div: RTL
========

DIV -- requirements
Module: div

Interface
REQ-001 Parameter: none; widths come from the shared defines (RegBus = 32 bits, DoubleRegBus = 64 bits).
REQ-002 clk  input  1  — single clock; all state updates on the rising edge.
REQ-003 rst  input  1  — reset is asynchronous and active-low (rst = 0 resets).
REQ-004 signed_div_i  input  1  — 1 = signed (DIV), 0 = unsigned (DIVU).
REQ-005 opdata1_i  input  32  — dividend.
REQ-006 opdata2_i  input  32  — divisor.
REQ-007 start_i  input  1  — DivStart / DivStop request from the execute stage.
REQ-008 annul_i  input  1  — 1 = abandon the current division (pipeline flush).
REQ-009 result_o  output  64  — {remainder[63:32], quotient[31:0]}; the execute stage writes [63:32] to HI and [31:0] to LO.
REQ-010 ready_o  output  1  — DivResultReady / DivResultNotReady.

Function
REQ-011 The FSM SHALL have four states: DivFree, DivByZero, DivOn and DivEnd.
REQ-012 DivFree, when start_i = 1 and annul_i = 0:
- opdata2_i == 0 → DivByZero.
- otherwise → DivOn, with cnt = 0 and dividend register (65 bits) = {32'b0, |opdata1_i|, 1'b0}.
- The absolute value is taken only when signed_div_i = 1 and the sign bit is 1.
- Divisor register = |opdata2_i|, under the same rule.
REQ-013 DivFree, in all other cases: hold; ready_o = 0; result_o = 0.
REQ-014 DivByZero SHALL load dividend = 0 and go to DivEnd on the next edge.
REQ-015 DivOn with annul_i = 1 SHALL go to DivFree immediately, with cnt = 0; no result is produced.
REQ-016 DivOn, cnt < 32: compute a 33-bit trial t = {1'b0, dividend[63:32]} − {1'b0, divisor}.
- t[32] = 1 → shift dividend left by 1, inserting 0.
- otherwise → dividend = {t[31:0], dividend[31:0], 1'b1}.
- cnt increments by 1.
REQ-017 DivOn, cnt == 32: sign correction, then go to DivEnd with cnt = 0.
- Quotient is negated (two's complement) if signed_div_i = 1 and opdata1_i[31] ^ opdata2_i[31] = 1.
- The remainder (dividend[64:33]) is negated if signed_div_i = 1 and opdata1_i[31] ^ remainder-sign = 1, so the remainder takes the dividend's sign.
REQ-018 DivEnd: result_o = {remainder, quotient}; ready_o = 1.
- The state holds while start_i = 1.
- When start_i = 0: go to DivFree, ready_o = 0, result_o = 0.
REQ-019 Latency: ready_o SHALL rise on edge N+34 for a non-zero divisor and on edge N+2 for a zero divisor, where edge N is the edge that sampled start_i = 1.
REQ-020 opdata1_i, opdata2_i and signed_div_i SHALL be held stable by the upstream stage while start_i = 1; the correction in REQ-017 reads them live.
REQ-021 A zero divisor SHALL produce result_o = 64'h0 and SHALL raise no exception.
REQ-022 A start_i pulse while in DivOn (without annul_i) SHALL be ignored.
REQ-023 annul_i SHALL have no effect in DivByZero or DivEnd.

Reset
REQ-024 While rst = 0, asynchronously: state = DivFree, cnt = 0, ready_o = 0, result_o = 0, dividend = 0, divisor = 0.
REQ-025 Reset asserted mid-division SHALL discard all progress.
REQ-026 After reset, start_i SHALL be honoured on the first rising edge at which rst = 1.

Structure
REQ-027 The state encodings (DivFree 2'b00, DivByZero 2'b01, DivOn 2'b10, DivEnd 2'b11) and DivStart, DivStop, DivResultReady and DivResultNotReady SHALL live in the shared defines file alongside RegBus and DoubleRegBus.
REQ-028 The module SHALL be flat, one FSM block plus the combinational trial subtractor; no sub-module is required.
REQ-029 Instantiation: between the execute stage's div_* outputs and its div_result_i / div_ready_i inputs, with annul_i driven by the pipeline-flush signal.

Verification
REQ-030 Signed 7 / −2 (0xFFFFFFFE) → result_o = {0x00000001, 0xFFFFFFFD}; ready_o rises on edge N+34.
REQ-031 Unsigned 0xFFFFFFFF / 0x00000010 → result_o = {0x0000000F, 0x0FFFFFFF}.
REQ-032 Signed −8 / −3 → result_o = {0xFFFFFFFE, 0x00000002}.
REQ-033 Divisor 0 with start_i = 1 → ready_o = 1 on edge N+2 with result_o = 64'h0.
- Dropping start_i returns the block to DivFree with ready_o = 0.
REQ-034 annul_i = 1 at cnt = 10 → DivFree on the next edge with ready_o never asserted.
- An immediately following unsigned 100 / 7 → {0x00000002, 0x0000000E}.
REQ-035 rst pulled low at cnt = 20 → all outputs are 0 asynchronously; a fresh 9 / 3 after release → {0x0, 0x3}.

Source files
------------

// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divider: bus widths, handshake
// encodings, FSM state encoding and the conditional absolute-value helper.
package div_pkg;

  localparam int RegBus       = 32;
  localparam int DoubleRegBus = 64;

  // Request / status encodings exchanged with the execute stage
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  // Iteration count of the restoring loop (one quotient bit per cycle)
  localparam logic [5:0] DivIterations = 6'd32;

  typedef enum logic [1:0] {
    DIV_FREE    = 2'b00,
    DIV_BY_ZERO = 2'b01,
    DIV_ON      = 2'b10,
    DIV_END     = 2'b11
  } div_state_e;

  // Two's-complement magnitude, taken only for a signed operation with a
  // negative operand; unsigned operands pass through untouched.
  function automatic logic [RegBus-1:0] abs_if_signed(input logic [RegBus-1:0] v,
                                                      input logic              is_signed);
    logic [RegBus-1:0] r;
    r = v;
    if (is_signed && v[RegBus-1]) begin
      r = ~v + 32'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/div.sv
// Multi-cycle restoring divider for the execute stage (DIV / DIVU).
// result_o = {remainder, quotient}; ready_o is high while the result is held.
//
// Handshake: the execute stage raises start_i (DivStart) with stable operands
// and keeps it high until it sees ready_o = DivResultReady; it then drops
// start_i (DivStop), which returns the block to idle and clears the outputs.
// A start_i pulse while a division is running is ignored. annul_i abandons a
// running division only; it does nothing while idle, in DIV_BY_ZERO or DIV_END.
module div
  import div_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    signed_div_i,
  input  logic [RegBus-1:0]       opdata1_i,
  input  logic [RegBus-1:0]       opdata2_i,
  input  logic                    start_i,
  input  logic                    annul_i,
  output logic [DoubleRegBus-1:0] result_o,
  output logic                    ready_o,
  output logic [1:0]              dbg_state_o
);

  div_state_e              state_q, state_d;
  logic [5:0]              cnt_q, cnt_d;
  logic [DoubleRegBus:0]   dividend_q, dividend_d;
  logic [RegBus-1:0]       divisor_q, divisor_d;
  logic [DoubleRegBus-1:0] result_q, result_d;
  logic                    ready_q, ready_d;

  // Trial subtraction of the divisor from the current partial remainder;
  // bit 32 set means the subtraction borrowed (partial remainder too small).
  logic [RegBus:0]         trial;

  // Combinational trial subtractor feeding the iteration step
  always_comb begin
    trial = {1'b0, dividend_q[63:32]} - {1'b0, divisor_q};
  end

  // Next-state and datapath update for the divider FSM
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    result_d   = result_q;
    ready_d    = ready_q;

    case (state_q)
      DIV_FREE: begin
        ready_d  = DivResultNotReady;
        result_d = '0;
        if (start_i == DivStart && !annul_i) begin
          if (opdata2_i == '0) begin
            state_d = DIV_BY_ZERO;
          end else begin
            state_d    = DIV_ON;
            cnt_d      = '0;
            dividend_d = {32'b0, abs_if_signed(opdata1_i, signed_div_i), 1'b0};
            divisor_d  = abs_if_signed(opdata2_i, signed_div_i);
          end
        end
      end

      DIV_BY_ZERO: begin
        // Zero divisor yields an all-zero result, no exception
        dividend_d = '0;
        state_d    = DIV_END;
      end

      DIV_ON: begin
        if (annul_i) begin
          state_d = DIV_FREE;
          cnt_d   = '0;
        end else if (cnt_q != DivIterations) begin
          if (trial[RegBus]) begin
            dividend_d = {dividend_q[63:0], 1'b0};
          end else begin
            dividend_d = {trial[31:0], dividend_q[31:0], 1'b1};
          end
          cnt_d = cnt_q + 6'd1;
        end else begin
          // Sign correction reads the (held-stable) operands live
          if (signed_div_i && (opdata1_i[31] ^ opdata2_i[31])) begin
            dividend_d[31:0] = ~dividend_q[31:0] + 32'd1;
          end
          if (signed_div_i && (opdata1_i[31] ^ dividend_q[64])) begin
            dividend_d[64:33] = ~dividend_q[64:33] + 32'd1;
          end
          state_d = DIV_END;
          cnt_d   = '0;
        end
      end

      DIV_END: begin
        result_d = {dividend_q[64:33], dividend_q[31:0]};
        ready_d  = DivResultReady;
        if (start_i == DivStop) begin
          state_d  = DIV_FREE;
          ready_d  = DivResultNotReady;
          result_d = '0;
        end
      end

      default: begin
        state_d = DIV_FREE;
      end
    endcase
  end

  // State and datapath registers; reset discards any division in flight
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= DIV_FREE;
      cnt_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      result_q   <= '0;
      ready_q    <= DivResultNotReady;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      result_q   <= result_d;
      ready_q    <= ready_d;
    end
  end

  assign result_o    = result_q;
  assign ready_o     = ready_q;
  assign dbg_state_o = state_q;

endmodule
